// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM states, default device ID and R/W bit encodings.
package sccb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_SUB,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } sccb_state_e;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
  localparam logic       RW_WRITE        = 1'b0;
  localparam logic       RW_READ         = 1'b1;
endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SIO_C/SIO_D into XCLK and emits registered SIO_C edge and START/STOP pulses.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sio_c,
  input  logic sio_d,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic c_s, d_s, scl;

  assign c_s = c_sync[SYNC_STAGES-1];
  assign d_s = d_sync[SYNC_STAGES-1];

  // scl/sda are the edge-detector flops; when a pulse is high they already hold the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync   <= '1;
      d_sync   <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      c_sync   <= {c_sync[SYNC_STAGES-2:0], sio_c};
      d_sync   <= {d_sync[SYNC_STAGES-2:0], sio_d};
      scl      <= c_s;
      sda      <= d_s;
      scl_rise <= c_s & ~scl;
      scl_fall <= ~c_s & scl;
      start    <= c_s & scl & sda & ~d_s;
      stop     <= c_s & scl & ~sda & d_s;
    end
  end
endmodule

// File: rtl/sccb_responder.sv
// SCCB camera-side responder with 256x8 register file and host port.
// Define SCCB_RESP_ACK_EN to drive an I2C-style ACK in the 9th bit of write phases.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       XCLK,
  input  logic       RST_N,
  input  logic       SIO_C,
  inout  wire        SIO_D,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_stb,
  output logic       busy
);
  sccb_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  sh, sh_nxt, ptr, ptr_nxt, byte_in;
  logic        oe, oe_nxt, ack_pend, ack_nxt, commit, rd_load;
  logic        sda, scl_rise, scl_fall, start, stop;
  logic [7:0]  regs [256];

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(XCLK), .rst_n(RST_N), .sio_c(SIO_C), .sio_d(SIO_D),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );

  // RST_N gates the driver so the line is released without waiting for a clock
  assign SIO_D   = (oe && RST_N) ? 1'b0 : 1'bz;
  assign busy    = (state != ST_IDLE);
  assign byte_in = {sh[6:0], sda};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    ptr_nxt   = ptr;
    oe_nxt    = oe;
    ack_nxt   = ack_pend;
    commit    = 1'b0;
    rd_load   = 1'b0;
    if (start || stop) begin
      state_nxt = start ? ST_ID : ST_IDLE;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
      ack_nxt   = 1'b0;
    end else if (state != ST_IDLE) begin
      if (scl_rise) begin
        if (cnt == 4'd8) begin
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (state != ST_RDATA) sh_nxt = byte_in;
          if (cnt == 4'd7) begin
            ack_nxt   = 1'b0;
            state_nxt = ST_IGNORE;
            case (state)
              ST_ID: if (byte_in[7:1] == DEV_ID[7:1]) begin
                ack_nxt = 1'b1;
                if (byte_in[0] == RW_READ) begin
                  state_nxt = ST_RDATA;
                  sh_nxt    = regs[ptr];
                  rd_load   = 1'b1;
                end else begin
                  state_nxt = ST_SUB;
                end
              end
              ST_SUB: begin
                ptr_nxt   = byte_in;
                state_nxt = ST_WDATA;
                ack_nxt   = 1'b1;
              end
              ST_WDATA: begin
                commit  = 1'b1;
                ack_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end else if (scl_fall) begin
        // cnt==8 on a fall opens the 9th-bit slot of the byte just completed
        if (cnt == 4'd8) begin
`ifdef SCCB_RESP_ACK_EN
          oe_nxt = ack_pend;
`else
          oe_nxt = 1'b0;
`endif
        end else if (state == ST_RDATA) begin
          oe_nxt = ~sh[3'd7 - cnt[2:0]];
        end else begin
          oe_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge XCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      sh         <= 8'h00;
      ptr        <= 8'h00;
      oe         <= 1'b0;
      ack_pend   <= 1'b0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      wr_addr    <= 8'h00;
      wr_data    <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh         <= sh_nxt;
      ptr        <= ptr_nxt;
      oe         <= oe_nxt;
      ack_pend   <= ack_nxt;
      wr_stb     <= commit;
      rd_stb     <= rd_load;
      host_rdata <= regs[host_addr];
      if (commit) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  // Later assignment wins, so an SCCB commit overrides a host write to the same address
  always_ff @(posedge XCLK) begin
    if (host_we) regs[host_addr] <= host_wdata;
    if (commit)  regs[ptr] <= byte_in;
  end
endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-level SCCB master plus transaction-level register model.
module tb_sccb_responder;
  localparam int Q = 10;
`ifdef SCCB_RESP_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       xclk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
  logic [7:0] host_rdata, wr_addr, wr_data;
  logic       wr_stb, rd_stb, busy;
  wire        sio_d;

  pullup (sio_d);
  assign sio_d = m_low ? 1'b0 : 1'bz;

  int          checks = 0, errors = 0, wr_cnt = 0, rd_cnt = 0, w0, r0;
  logic [7:0]  mregs [256];
  logic [7:0]  mptr = 8'h00;
  logic [15:0] wr_q [$];
  logic [15:0] wr_e;
  bit          chk_rel = 1'b0;

  always #10 xclk = ~xclk;

  sccb_responder #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
    .XCLK(xclk), .RST_N(rst_n), .SIO_C(scl), .SIO_D(sio_d),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_stb(rd_stb), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Commits are checked against the transaction model and only then applied to it
  always @(negedge xclk) begin
    if (rst_n) begin
      if (wr_stb) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected actual=%0h required=none", {wr_addr, wr_data});
        end else begin
          wr_e = wr_q.pop_front();
          chk("wr_commit", {wr_addr, wr_data}, wr_e);
          mregs[wr_e[15:8]] = wr_e[7:0];
        end
      end
      if (rd_stb) rd_cnt++;
      if (chk_rel && !m_low) chk("sio_released", sio_d, 1);
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    wq(1); host_we = 1'b1; host_addr = a; host_wdata = d; mregs[a] = d;
    wq(1); host_we = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    wq(1); host_addr = a;
    wq(2); chk(name, host_rdata, exp);
  endtask

  task automatic m_start();
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b1; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic m_stop();
    m_low = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b0; wq(2*Q);
  endtask

  // coll: raise host_we on the XCLK where the commit of this rising edge lands
  task automatic m_bit(input bit b, input bit coll, input logic [7:0] ca, input logic [7:0] cd);
    m_low = !b; wq(Q); scl = 1'b1;
    if (coll) begin
      wq(3); host_we = 1'b1; host_addr = ca; host_wdata = cd; mregs[ca] = cd;
      wq(1); host_we = 1'b0; wq(2*Q-4);
    end else wq(2*Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic m_ack(input string name, input bit exp_drv);
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
    chk(name, sio_d, (ACK_EN && exp_drv) ? 1'b0 : 1'b1);
    wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic m_byte(input logic [7:0] b, input string ack_name, input bit exp_ack,
                        input bit coll, input logic [7:0] ca, input logic [7:0] cd);
    for (int i = 7; i >= 0; i--) m_bit(b[i], coll && (i == 0), ca, cd);
    m_ack(ack_name, exp_ack);
  endtask

  task automatic m_read(input string name, input logic [7:0] exp);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); got[i] = sio_d; wq(Q); scl = 1'b0; wq(Q);
    end
    chk(name, got, exp);
    m_ack("rd_na_released", 1'b0);
  endtask

  task automatic sccb_write3(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data,
                             input bit coll, input logic [7:0] ca, input logic [7:0] cd);
    bit match;
    match = (id[7:1] == 7'h21) && !id[0];
    m_start();
    m_byte(id, "ack_id", match, 1'b0, 8'h00, 8'h00);
    m_byte(sub, "ack_sub", match, 1'b0, 8'h00, 8'h00);
    if (match) begin mptr = sub; wr_q.push_back({sub, data}); end
    m_byte(data, "ack_wdata", match, coll, ca, cd);
    m_stop();
  endtask

  task automatic sccb_write2(input logic [7:0] id, input logic [7:0] sub);
    m_start();
    m_byte(id, "ack_id2", 1'b1, 1'b0, 8'h00, 8'h00);
    m_byte(sub, "ack_sub2", 1'b1, 1'b0, 8'h00, 8'h00);
    mptr = sub;
    m_stop();
  endtask

  task automatic sccb_read(input string name, input logic [7:0] lit);
    m_start();
    m_byte(8'h43, "ack_rid", 1'b1, 1'b0, 8'h00, 8'h00);
    chk({name, "_lit"}, mregs[mptr], lit);
    m_read(name, mregs[mptr]);
    m_stop();
  endtask

  initial begin
    wq(5);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_stb", rd_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sio", sio_d, 1);
    rst_n = 1'b1; wq(5);

    host_write(8'h00, 8'hA5);
    host_write(8'h30, 8'h3C);

    // 3-phase write
    w0 = wr_cnt;
    sccb_write3(8'h42, 8'h12, 8'h80, 1'b0, 8'h00, 8'h00);
    chk("w3_once", wr_cnt - w0, 1);
    chk("w3_addr", wr_addr, 8'h12);
    chk("w3_data", wr_data, 8'h80);
    host_read("w3_host", 8'h12, 8'h80);

    // preload, 2-phase write then 2-phase read
    host_write(8'h0A, 8'h76);
    sccb_write2(8'h42, 8'h0A);
    r0 = rd_cnt;
    sccb_read("rd_0a", 8'h76);
    chk("rd_once", rd_cnt - r0, 1);

    // foreign ID: line never driven, no commit
    w0 = wr_cnt; chk_rel = 1'b1;
    m_start();
    chk("ign_busy", busy, 1);
    m_byte(8'h60, "ign_id", 1'b0, 1'b0, 8'h00, 8'h00);
    m_byte(8'h05, "ign_sub", 1'b0, 1'b0, 8'h00, 8'h00);
    m_byte(8'h99, "ign_data", 1'b0, 1'b0, 8'h00, 8'h00);
    chk("ign_busy_mid", busy, 1);
    m_stop();
    chk_rel = 1'b0;
    chk("ign_busy_stop", busy, 0);
    chk("ign_no_wr", wr_cnt - w0, 0);

    // STOP after four data bits: pointer moves, no commit
    w0 = wr_cnt;
    m_start();
    m_byte(8'h42, "ack_id_p", 1'b1, 1'b0, 8'h00, 8'h00);
    m_byte(8'h30, "ack_sub_p", 1'b1, 1'b0, 8'h00, 8'h00);
    mptr = 8'h30;
    for (int i = 0; i < 4; i++) m_bit(i[0], 1'b0, 8'h00, 8'h00);
    m_stop();
    chk("part_no_wr", wr_cnt - w0, 0);
    host_read("part_regs", 8'h30, 8'h3C);

    // repeated START three bits into SUB
    w0 = wr_cnt;
    m_start();
    m_byte(8'h42, "ack_id_r", 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) m_bit(1'b1, 1'b0, 8'h00, 8'h00);
    sccb_write3(8'h42, 8'h31, 8'h77, 1'b0, 8'h00, 8'h00);
    chk("rs_once", wr_cnt - w0, 1);
    host_read("rs_host", 8'h31, 8'h77);

    // host write colliding with commit: same address, then different address
    sccb_write3(8'h42, 8'h20, 8'h5A, 1'b1, 8'h20, 8'h11);
    host_read("coll_same", 8'h20, 8'h5A);
    sccb_write3(8'h42, 8'h22, 8'hC3, 1'b1, 8'h23, 8'h33);
    host_read("coll_diff_sccb", 8'h22, 8'hC3);
    host_read("coll_diff_host", 8'h23, 8'h33);

    // reset while driving a read bit, then a read from pointer 0
    sccb_write2(8'h42, 8'h0A);
    m_start();
    m_byte(8'h43, "ack_rid_rst", 1'b1, 1'b0, 8'h00, 8'h00);
    wq(Q);
    chk("rd_bit7_driven", sio_d, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sio", sio_d, 1);
    chk("rst_mid_busy", busy, 0);
    scl = 1'b1; m_low = 1'b0; wq(2*Q);
    rst_n = 1'b1; wq(2*Q);
    mptr = 8'h00;
    sccb_read("rd_after_rst", 8'hA5);

    chk("wr_q_drained", wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_responder.md
# sccb_responder

Camera-side SCCB (2-wire) slave that mirrors the SCCB master used to configure the OV-class sensor. It accepts 3-phase writes, 2-phase writes and 2-phase reads, and holds a 256×8 register file that a host port can preload and read back. It serves as the behavioural camera model in the FreeRTOS/Mi-V simulation bench, and as an on-fabric loopback target for bring-up of the master.

## Interface
Parameters:
- DEV_ID, 8'h42: 8-bit device ID. Bits [7:1] are compared; bit 0 is the R/W bit.
- SYNC_STAGES, 2: synchronizer depth on SIO_C and SIO_D (minimum 2).

Ports:
- XCLK  in  1: system clock (50 MHz). This is the block's one clock.
- RST_N  in  1: reset, asynchronous, active-low.
- SIO_C  in  1: SCCB clock from the master.
- SIO_D  inout  1: SCCB data, open-drain. The block drives only 0 or z.
- host_we  in  1: host write strobe into the register file.
- host_addr  in  8: host register address.
- host_wdata  in  8: host write data.
- host_rdata  out  8: registered read of regs[host_addr], 1-cycle latency.
- wr_stb  out  1: 1-cycle pulse when an SCCB 3-phase write commits.
- wr_addr  out  8: sub-address of the last commit.
- wr_data  out  8: data of the last commit.
- rd_stb  out  1: 1-cycle pulse when an SCCB read byte is loaded.
- busy  out  1: high from START until STOP or abort.

## Operation
- SIO_C and SIO_D pass through SYNC_STAGES flops, then a 1-flop edge detector. All decisions use the synchronized copies.
- START is SIO_D falling while SIO_C is high. STOP is SIO_D rising while SIO_C is high. Data is sampled on SIO_C rising and driven on SIO_C falling.
- States:
  - IDLE
  - ID: 8 bits, then the 9th (don't-care) bit.
  - SUB: 8 bits + 9th bit.
  - WDATA: 8 bits + 9th bit.
  - RDATA: 8 bits + 9th bit.
  - IGNORE
- 4-bit bit counter, 0..8. Count 8 is the don't-care/ACK slot.
- State transitions:
  - START in any state → ID. This covers repeated START; any partial byte is discarded.
  - ID complete:
    - id[7:1] ≠ DEV_ID[7:1] → IGNORE.
    - R/W = 0 → SUB.
    - R/W = 1 → RDATA; shift register loads regs[ptr] and rd_stb pulses.
  - SUB complete → ptr ← sub, then WDATA.
  - STOP in WDATA before any bit arrives is a 2-phase write: pointer updated only, → IDLE.
  - WDATA complete → regs[ptr] ← data, wr_stb pulse, wr_addr/wr_data updated, then IGNORE. Further bytes are ignored; there is no auto-increment.
  - RDATA: MSB first. Bit 1 releases SIO_D (z); bit 0 drives 0. At bit 8 SIO_D is released. The master's NA value is ignored. Then → IGNORE.
  - STOP in any state → IDLE. No commit occurs unless WDATA already completed.
- Simultaneous host_we and SCCB commit to the same address: SCCB wins. Different addresses: both writes occur.
- The register file is not reset. ptr resets to 0.

## Timing
- Reset values: SIO_D z; host_rdata 0; wr_stb 0; wr_addr 0; wr_data 0; rd_stb 0; busy 0. State is IDLE.
- Edge detection latency: SYNC_STAGES+1 XCLK after the pin edge.
- SIO_D drive changes ≤ SYNC_STAGES+2 XCLK after SIO_C falls.
- Required SIO_C high and low time: ≥ 2·(SYNC_STAGES+2) XCLK. At the master's 100 kHz rate this gives 250 XCLK, so margin is large.
- wr_stb asserts SYNC_STAGES+2 XCLK after the SIO_C rising edge that samples data bit 0.
- Reset mid-transaction: SIO_D is released the same cycle, asynchronously via the output enable.

## Configuration
- SCCB_RESP_ACK_EN defined: the block drives SIO_D low during the 9th bit of ID (on a match), SUB and WDATA, which makes it I2C-ACK compatible.
- SCCB_RESP_ACK_EN undefined: SIO_D stays z in every 9th bit, which is pure SCCB don't-care. RDATA bit 8 is always released in both builds.

## Structure
- The shared package sccb_pkg holds:
  - the state enum;
  - the SCCB_DEFAULT_ID = 8'h42 constant;
  - the RW_WRITE/RW_READ constants.
  The master's future refactor uses the same package.
- One sub-module, sccb_line_sync, contains the synchronizers, the edge detector and START/STOP detection. It is instantiated once.

## Test plan
- 3-phase write: ID 0x42, sub 0x12, data 0x80, STOP → wr_stb=1 once; wr_addr=0x12; wr_data=0x80; host read of 0x12 gives 0x80.
- Host preloads regs[0x0A]=0x76. Then 2-phase write (ID 0x42, sub 0x0A, STOP) followed by 2-phase read (ID 0x43) → SIO_D shows 0x76 MSB-first and rd_stb pulses once.
- ID 0x60 write → no wr_stb; SIO_D z for the whole transaction; busy drops at STOP.
- STOP after 4 data bits of WDATA → no commit; regs unchanged. Repeated START mid-SUB → a fresh ID is decoded correctly.
- With SCCB_RESP_ACK_EN: SIO_D=0 in the 9th bit of all three write phases. Without it: z.
- RST_N low during RDATA → SIO_D z immediately. After release, a read returns regs[0x00] (ptr=0).
